instr_fetch_unit: RTL

- Sits directly upstream of the multicycle controller.
- Owns the architectural PC register and the instruction register (IR). Runs the memory read handshake for instruction fetch and presents a stable Instr word to the controller's decode and condition logic.
- Stretches the controller's fetch state with a stall signal when memory is slow.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit_fetch_fsm.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 53 +++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM state encoding, reset/error constants
// and the word-alignment helper used when forming instruction addresses.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] ERR_INSTR_DEF = 32'hE7F0_00F0;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: request/address out, single-cycle ack with data back.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/instr_fetch_unit_fetch_fsm.sv
// Fetch handshake sequencer: IDLE -> WAIT -> DONE, with a saturating wait
// counter that turns a missing ack into a timeout.
module fetch_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_write,
    input  logic [31:0] fetch_adr,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        stall,
    output logic        ir_load,
    output logic        ir_err
);

    fetch_state_e state;
    logic [7:0]   wait_cnt;
    logic [31:0]  addr_q;
    logic         start;
    logic         in_wait;
    logic         timeout;

    // Gating start with reset keeps the request low while reset is held,
    // even though the FSM sits in IDLE and IRWrite may toggle.
    assign start   = reset && (state == FS_IDLE) && ir_write;
    assign in_wait = (state == FS_WAIT);
    assign timeout = in_wait && !mem_ack && (wait_cnt >= 8'(WAIT_MAX - 1));
    assign ir_load = in_wait && mem_ack;
    assign ir_err  = timeout;
    assign mem_req = start || in_wait;
    assign mem_addr = start ? fetch_adr : addr_q;
    assign stall   = start || (in_wait && !mem_ack && !timeout);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FS_IDLE;
            wait_cnt <= 8'd0;
            addr_q   <= 32'd0;
        end else begin
            case (state)
                FS_IDLE: if (ir_write) begin
                    addr_q   <= fetch_adr;
                    wait_cnt <= 8'd0;
                    state    <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (mem_ack || timeout) state <= FS_DONE;
                    else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                end
                // One dead cycle so a strobe held over the completing edge does not refetch.
                FS_DONE: state <= FS_IDLE;
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, drives the memory read handshake
// and stalls the controller's fetch state until the word is in the IR.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned WAIT_MAX  = 16,
    parameter logic [31:0] ERR_INSTR = ERR_INSTR_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      IRWrite,
    input  logic                      PCWrite,
    input  logic [31:0]               PCNext,
    instr_fetch_unit_if.master        mem,
    output logic [31:0]               PC,
    output logic [31:0]               Instr,
    output logic                      FetchStall,
    output logic                      FetchErr
);

    logic ir_load;
    logic ir_err;

    fetch_fsm #(.WAIT_MAX(WAIT_MAX)) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .ir_write  (IRWrite),
        .fetch_adr (word_align(PC)),
        .mem_ack   (mem.mem_ack),
        .mem_req   (mem.mem_req),
        .mem_addr  (mem.mem_addr),
        .stall     (FetchStall),
        .ir_load   (ir_load),
        .ir_err    (ir_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC       <= RESET_PC;
            Instr    <= 32'd0;
            FetchErr <= 1'b0;
        end else begin
            if (PCWrite) PC <= PCNext;
            if (ir_load) Instr <= mem.mem_rdata;
            else if (ir_err) begin
                Instr    <= ERR_INSTR;
                FetchErr <= 1'b1;
            end
        end
    end

endmodule
